// File: rtl/wb_regfile.sv
// wb_regfile -- write-back stage register plus 32x32 architectural register file.
//
// The memory-access result (regData_i/regAddr_i/regWr_i) is captured into the
// WB slot on every edge. On the next edge the slot commits to the GPR array.
// While the slot waits to commit, it bypasses to the two combinational read
// ports. The slot is also exported as a forwarding source for execute.
//
// Ports
//   clk, rst               clock; asynchronous active-low reset
//   regData_i/regAddr_i/   result, destination and write enable from the
//   regWr_i                memory-access stage
//   rAddr1/rAddr2          read indices
//   rData1/rData2          combinational read data (r0 reads 0, slot bypass)
//   fwdData/fwdAddr/fwdWr  WB slot copy; fwdWr is cleared for r0
//   retireCnt              committed-write counter
//
// Optional feature: define WB_RETIRE_CNT_EN to build retireCnt. Without the
// macro, retireCnt is tied to zero and no counter logic is built.

// One read port: r0 reads zero, a pending slot write wins, else the array.
module wb_rd_port #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32
) (
  input  logic [REG_NUM-1:0][DATA_W-1:0] gpr,
  input  logic                           byp_wr,
  input  logic [ADDR_W-1:0]              byp_addr,
  input  logic [DATA_W-1:0]              byp_data,
  input  logic [ADDR_W-1:0]              raddr,
  output logic [DATA_W-1:0]              rdata
);
  always_comb begin
    rdata = gpr[raddr];
    if (raddr == '0)                         rdata = '0;
    else if (byp_wr && byp_addr == raddr)    rdata = byp_data;
  end
endmodule

module wb_regfile #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] regData_i,
  input  logic [ADDR_W-1:0] regAddr_i,
  input  logic              regWr_i,
  input  logic [ADDR_W-1:0] rAddr1,
  input  logic [ADDR_W-1:0] rAddr2,
  output logic [DATA_W-1:0] rData1,
  output logic [DATA_W-1:0] rData2,
  output logic [DATA_W-1:0] fwdData,
  output logic [ADDR_W-1:0] fwdAddr,
  output logic              fwdWr,
  output logic [31:0]       retireCnt
);
  localparam int NUM_RD = 2;

  // WB slot
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic              wb_wr_q,   wb_wr_d;
  logic              commit;

  // GPR array; entry 0 is never written and stays at its reset value.
  logic [REG_NUM-1:0][DATA_W-1:0] gpr_q, gpr_d;

  // A write to r0 is not a real write, so it neither commits nor forwards.
  assign commit = wb_wr_q && (wb_addr_q != '0);

  always_comb begin
    wb_data_d = regData_i;
    wb_addr_d = regAddr_i;
    wb_wr_d   = regWr_i;
    gpr_d     = gpr_q;
    if (commit) gpr_d[wb_addr_q] = wb_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_data_q <= '0;
      wb_addr_q <= '0;
      wb_wr_q   <= 1'b0;
      gpr_q     <= '0;
    end else begin
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
      wb_wr_q   <= wb_wr_d;
      gpr_q     <= gpr_d;
    end
  end

  assign fwdData = wb_data_q;
  assign fwdAddr = wb_addr_q;
  assign fwdWr   = commit;

  // Read ports
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;

  assign rd_addr[0] = rAddr1;
  assign rd_addr[1] = rAddr2;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    wb_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_NUM(REG_NUM)) u_rd (
      .gpr      (gpr_q),
      .byp_wr   (commit),
      .byp_addr (wb_addr_q),
      .byp_data (wb_data_q),
      .raddr    (rd_addr[p]),
      .rdata    (rd_data[p])
    );
  end

  assign rData1 = rd_data[0];
  assign rData2 = rd_data[1];

`ifdef WB_RETIRE_CNT_EN
  // The counter advances on the edge where the array is actually written.
  // It wraps silently.
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (commit) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign retireCnt = cnt_q;
`else
  assign retireCnt = 32'd0;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized plus directed bench for wb_regfile.
//
// The reference model treats the block as an architectural register file.
// A write presented at an edge is visible to every read from then on, except
// writes to r0. Reset clears the model. The model also tracks the forwarding
// slot and the count of retired writes.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] regData_i;
  logic [4:0]  regAddr_i;
  logic        regWr_i;
  logic [4:0]  rAddr1, rAddr2;
  logic [31:0] rData1, rData2, fwdData, retireCnt;
  logic [4:0]  fwdAddr;
  logic        fwdWr;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] ref_mem [32];
  logic [31:0] ref_fdata;
  logic [4:0]  ref_faddr;
  logic        ref_fwr;
  logic [31:0] ref_cnt;
  logic        ref_pend;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .regData_i(regData_i), .regAddr_i(regAddr_i), .regWr_i(regWr_i),
    .rAddr1(rAddr1), .rAddr2(rAddr2), .rData1(rData1), .rData2(rData2),
    .fwdData(fwdData), .fwdAddr(fwdAddr), .fwdWr(fwdWr),
    .retireCnt(retireCnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    return (a == 0) ? 32'd0 : ref_mem[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    ref_fdata = '0; ref_faddr = '0; ref_fwr = 1'b0;
    ref_cnt = '0; ref_pend = 1'b0;
  endtask

  // One clock edge; the model absorbs the inputs that were presented.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      if (ref_pend) ref_cnt = ref_cnt + 1;
      ref_pend  = regWr_i && regAddr_i != 0;
      ref_fdata = regData_i;
      ref_faddr = regAddr_i;
      ref_fwr   = ref_pend;
      if (ref_pend) ref_mem[regAddr_i] = regData_i;
    end
    #1;
  endtask

  task automatic chk_all(input string tag);
    #1;
    chk({tag, ".rd1"}, rData1, ref_rd(rAddr1));
    chk({tag, ".rd2"}, rData2, ref_rd(rAddr2));
    chk({tag, ".fdata"}, fwdData, ref_fdata);
    chk({tag, ".faddr"}, {27'd0, fwdAddr}, {27'd0, ref_faddr});
    chk({tag, ".fwr"}, {31'd0, fwdWr}, {31'd0, ref_fwr});
`ifdef WB_RETIRE_CNT_EN
    chk({tag, ".cnt"}, retireCnt, ref_cnt);
`else
    chk({tag, ".cnt"}, retireCnt, 32'd0);
`endif
  endtask

  task automatic rand_in();
    regData_i = $urandom;
    regAddr_i = 5'($urandom_range(0, 7));
    regWr_i   = 1'($urandom);
    rAddr1    = 5'($urandom_range(0, 7));
    rAddr2    = 5'($urandom_range(0, 7));
  endtask

  // Asynchronous reset pulse placed away from any clock edge.
  task automatic rst_pulse();
    rst = 1'b0;
    model_clear();
    chk_all("rst_pulse");
    #1 rst = 1'b1;
  endtask

  initial begin
    model_clear();
    rst = 1'b0;
    rand_in();
    // hold reset across edges with random inputs
    for (int i = 0; i < 4; i++) begin
      tick();
      rand_in();
      chk_all("in_reset");
    end
    rst = 1'b1;
    regWr_i = 1'b0;
    tick();
    for (int a = 1; a < 32; a++) begin
      rAddr1 = 5'(a); rAddr2 = 5'(31 - a + 1);
      #1;
      chk("post_rst.rd1", rData1, 32'd0);
      chk("post_rst.rd2", rData2, 32'd0);
    end

    // write/read with bypass, then from the array
    regWr_i = 1'b1; regAddr_i = 5'd5; regData_i = 32'hDEADBEEF; rAddr1 = 5'd5;
    tick();
    regWr_i = 1'b0;
    #1;
    chk("wr.bypass", rData1, 32'hDEADBEEF);
    chk("wr.fwdwr", {31'd0, fwdWr}, 32'd1);
    chk("wr.fwdaddr", {27'd0, fwdAddr}, 32'd5);
    tick();
    chk("wr.array", rData1, 32'hDEADBEEF);
    chk("wr.fwdwr0", {31'd0, fwdWr}, 32'd0);

    // writes to r0 are dropped
    regWr_i = 1'b1; regAddr_i = 5'd0; regData_i = 32'h1234; rAddr1 = 5'd0;
    tick();
    regWr_i = 1'b0;
    #1;
    chk("r0.fwdwr", {31'd0, fwdWr}, 32'd0);
    chk("r0.rd1", rData1, 32'd0);
    tick();
    chk_all("r0.after");

    // back-to-back writes to the same register
    rAddr2 = 5'd7;
    regWr_i = 1'b1; regAddr_i = 5'd7; regData_i = 32'hA;
    tick();
    regData_i = 32'hB;
    #1 chk("b2b.first", rData2, 32'hA);
    tick();
    regWr_i = 1'b0;
    #1 chk("b2b.second", rData2, 32'hB);
    tick();
    chk("b2b.persist", rData2, 32'hB);

    // reset while the slot holds a valid write
    regWr_i = 1'b1; regAddr_i = 5'd3; regData_i = 32'h55; rAddr1 = 5'd3;
    tick();
    regWr_i = 1'b0;
    rst_pulse();
    tick();
    chk("midrst.fwdwr", {31'd0, fwdWr}, 32'd0);
    chk("midrst.r3", rData1, 32'd0);

`ifdef WB_RETIRE_CNT_EN
    // retire counter: ten real writes and two r0 writes
    rst_pulse();
    for (int i = 1; i <= 12; i++) begin
      regWr_i = 1'b1;
      regAddr_i = (i > 10) ? 5'd0 : 5'(i);
      regData_i = $urandom;
      tick();
    end
    regWr_i = 1'b0;
    tick(); tick();
    chk("cnt.ten", retireCnt, 32'd10);
`endif

    // random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      rand_in();
      if ($urandom_range(0, 99) < 3) rst_pulse();
      chk_all("rand");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
